// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm: miss handler that refills one cache block from main memory.
// On a miss it latches the block address, streams eight word reads to memory
// on consecutive cycles, and steers each returned word straight into the data
// array in return order. The tag entry is written alongside the final word.
module cache_fill_fsm #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 16,
    parameter int OFFSET_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              miss_detected,
    input  logic [ADDR_W-1:0] miss_address,
    input  logic              mem_data_valid,
    input  logic [DATA_W-1:0] mem_data_in,
    output logic              fsm_busy,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [ADDR_W-1:0] fill_addr,
    output logic [DATA_W-1:0] fill_data,
    output logic              write_data_array,
    output logic              write_tag_array
);

    // Block geometry: words are 2 bytes, so the word index is one bit
    // narrower than the byte offset and byte bit 0 is always zero.
    localparam int BASE_W = ADDR_W - OFFSET_W;
    localparam int WIDX_W = OFFSET_W - 1;
    localparam int WORDS  = 2 ** WIDX_W;

    // Request counter runs 0..WORDS, so it needs one bit more than a word index.
    localparam logic [OFFSET_W-1:0] REQ_DONE  = OFFSET_W'(WORDS);
    localparam logic [WIDX_W-1:0]   LAST_WORD = '1;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [BASE_W-1:0]   blk_base_q, blk_base_d;
    logic [OFFSET_W-1:0] req_cnt_q, req_cnt_d;
    logic [WIDX_W-1:0]   rsp_cnt_q, rsp_cnt_d;

    // Byte-offset bits of the miss address never matter: fills always start
    // at word 0 of the block.
    logic miss_offset_unused;
    assign miss_offset_unused = ^miss_address[OFFSET_W-1:0];

    // Register state and counters; reset wins over any miss on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            blk_base_q <= '0;
            req_cnt_q  <= '0;
            rsp_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            blk_base_q <= blk_base_d;
            req_cnt_q  <= req_cnt_d;
            rsp_cnt_q  <= rsp_cnt_d;
        end
    end

    // Next-state logic: accept a miss in IDLE, count requests and responses
    // in FILL, and return to IDLE on the last returned word.
    always_comb begin
        state_d    = state_q;
        blk_base_d = blk_base_q;
        req_cnt_d  = req_cnt_q;
        rsp_cnt_d  = rsp_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (miss_detected) begin
                    state_d    = FILL;
                    blk_base_d = miss_address[ADDR_W-1:OFFSET_W];
                    req_cnt_d  = '0;
                    rsp_cnt_d  = '0;
                end
            end
            FILL: begin
                if (req_cnt_q < REQ_DONE) begin
                    req_cnt_d = req_cnt_q + 1'b1;
                end
                if (mem_data_valid) begin
                    rsp_cnt_d = rsp_cnt_q + 1'b1;
                    if (rsp_cnt_q == LAST_WORD) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are purely combinational so a returned word lands in the data
    // array in the same cycle it arrives; everything is quiet in IDLE.
    always_comb begin
        fsm_busy         = 1'b0;
        mem_rd_en        = 1'b0;
        mem_addr         = '0;
        fill_addr        = '0;
        fill_data        = '0;
        write_data_array = 1'b0;
        write_tag_array  = 1'b0;
        if (state_q == FILL) begin
            fsm_busy         = 1'b1;
            mem_rd_en        = (req_cnt_q < REQ_DONE);
            mem_addr         = {blk_base_q, req_cnt_q[WIDX_W-1:0], 1'b0};
            fill_addr        = {blk_base_q, rsp_cnt_q, 1'b0};
            fill_data        = mem_data_in;
            write_data_array = mem_data_valid;
            write_tag_array  = mem_data_valid && (rsp_cnt_q == LAST_WORD);
        end
    end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// tb_cache_fill_fsm: directed bench for the cache block fill handler.
// A queue-based model of expected requests and fills is compared against the
// DUT every cycle, and hand-computed literals pin key cycles of each scenario.
module tb_cache_fill_fsm;

    logic        clk;
    logic        rst;
    logic        miss_detected;
    logic [15:0] miss_address;
    logic        mem_data_valid;
    logic [15:0] mem_data_in;
    logic        fsm_busy;
    logic        mem_rd_en;
    logic [15:0] mem_addr;
    logic [15:0] fill_addr;
    logic [15:0] fill_data;
    logic        write_data_array;
    logic        write_tag_array;

    int checks = 0;
    int errors = 0;
    bit model_en = 0;
    bit m_busy = 0;
    int wr_seen = 0;
    logic [15:0] exp_req_q[$];
    logic [15:0] exp_fill_q[$];

    cache_fill_fsm #(
        .ADDR_W  (16),
        .DATA_W  (16),
        .OFFSET_W(4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .miss_detected   (miss_detected),
        .miss_address    (miss_address),
        .mem_data_valid  (mem_data_valid),
        .mem_data_in     (mem_data_in),
        .fsm_busy        (fsm_busy),
        .mem_rd_en       (mem_rd_en),
        .mem_addr        (mem_addr),
        .fill_addr       (fill_addr),
        .fill_data       (fill_data),
        .write_data_array(write_data_array),
        .write_tag_array (write_tag_array)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Guard against a hung run.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish, got running required finished");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs just after the rising edge, then settle.
    task automatic applyStimulus(input logic r, input logic m, input logic [15:0] a,
                                 input logic v, input logic [15:0] d);
        @(posedge clk);
        #1;
        rst            = r;
        miss_detected  = m;
        miss_address   = a;
        mem_data_valid = v;
        mem_data_in    = d;
        #1;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_busy"}, fsm_busy, 16'h0);
        checkOutput({tag, "_rd_en"}, mem_rd_en, 16'h0);
        checkOutput({tag, "_mem_addr"}, mem_addr, 16'h0);
        checkOutput({tag, "_fill_addr"}, fill_addr, 16'h0);
        checkOutput({tag, "_fill_data"}, fill_data, 16'h0);
        checkOutput({tag, "_wr_data"}, write_data_array, 16'h0);
        checkOutput({tag, "_wr_tag"}, write_tag_array, 16'h0);
    endtask

    // Behavioural model: a miss queues eight word addresses for requests and
    // eight for fills; each cycle the heads of those queues are what the DUT
    // must present, and the fill ends when the last queued word is written.
    always @(negedge clk) begin : compare_proc
        logic        e_rd;
        logic        e_wr;
        logic        e_tag;
        logic [15:0] e_maddr;
        logic [15:0] e_faddr;
        if (model_en) begin
            e_rd    = m_busy && (exp_req_q.size() > 0);
            e_maddr = e_rd ? exp_req_q[0] : 16'h0;
            e_wr    = m_busy && (mem_data_valid === 1'b1);
            e_faddr = (e_wr && exp_fill_q.size() > 0) ? exp_fill_q[0] : 16'h0;
            e_tag   = e_wr && (exp_fill_q.size() == 1);

            checkOutput("model_busy", fsm_busy, m_busy);
            checkOutput("model_rd_en", mem_rd_en, e_rd);
            if (e_rd) checkOutput("model_mem_addr", mem_addr, e_maddr);
            checkOutput("model_wr_data", write_data_array, e_wr);
            if (e_wr) begin
                checkOutput("model_fill_addr", fill_addr, e_faddr);
                checkOutput("model_fill_data", fill_data, mem_data_in);
            end
            checkOutput("model_wr_tag", write_tag_array, e_tag);
            if (write_data_array === 1'b1) wr_seen++;

            if (rst) begin
                m_busy = 0;
                exp_req_q.delete();
                exp_fill_q.delete();
            end else if (!m_busy) begin
                if (miss_detected) begin
                    m_busy = 1;
                    for (int i = 0; i < 8; i++) begin
                        exp_req_q.push_back((miss_address & 16'hFFF0) + 16'(2 * i));
                        exp_fill_q.push_back((miss_address & 16'hFFF0) + 16'(2 * i));
                    end
                end
            end else begin
                if (e_rd) void'(exp_req_q.pop_front());
                if (e_wr) void'(exp_fill_q.pop_front());
                if (e_tag) m_busy = 0;
            end
        end
    end

    // Directed scenarios with literal expectations at key cycles.
    initial begin : stim_proc
        int          bcnt;
        int          wr_start;
        logic [31:0] gap_mask;
        logic        v;
        rst            = 1'b1;
        miss_detected  = 1'b0;
        miss_address   = 16'h0;
        mem_data_valid = 1'b0;
        mem_data_in    = 16'h0;

        // Reset held two cycles.
        $display("[TB] reset");
        applyStimulus(1, 0, 16'h0, 0, 16'h0);
        checkAllZero("rst1");
        model_en = 1;
        applyStimulus(1, 0, 16'h0, 0, 16'h0);
        checkAllZero("rst2");

        // Miss at 0x1A36, 4-cycle memory; a second miss at 0x2040 is raised
        // mid-fill and kept high into the first IDLE cycle.
        $display("[TB] basic fill with ignored second miss");
        for (int k = 0; k < 14; k++) begin
            v = (k >= 5 && k <= 12);
            applyStimulus(0, (k == 0) || (k >= 3), (k == 0) ? 16'h1A36 : 16'h2040,
                          v, v ? 16'h00A0 + 16'(k - 5) : 16'h0);
            case (k)
                1: begin
                    checkOutput("t2_addr_c1", mem_addr, 16'h1A30);
                    checkOutput("t2_rd_c1", mem_rd_en, 16'h1);
                    checkOutput("t2_busy_c1", fsm_busy, 16'h1);
                end
                4: checkOutput("t3_addr_c4_held_base", mem_addr, 16'h1A36);
                5: begin
                    checkOutput("t2_wr_c5", write_data_array, 16'h1);
                    checkOutput("t2_faddr_c5", fill_addr, 16'h1A30);
                    checkOutput("t2_fdata_c5", fill_data, 16'h00A0);
                end
                8: checkOutput("t2_addr_c8", mem_addr, 16'h1A3E);
                9: begin
                    checkOutput("t2_rd_c9", mem_rd_en, 16'h0);
                    checkOutput("t2_busy_c9", fsm_busy, 16'h1);
                end
                11: checkOutput("t2_tag_c11", write_tag_array, 16'h0);
                12: begin
                    checkOutput("t2_tag_c12", write_tag_array, 16'h1);
                    checkOutput("t2_faddr_c12", fill_addr, 16'h1A3E);
                    checkOutput("t2_fdata_c12", fill_data, 16'h00A7);
                end
                13: begin
                    checkOutput("t2_busy_c13", fsm_busy, 16'h0);
                    checkOutput("t2_wr_c13", write_data_array, 16'h0);
                end
                default: ;
            endcase
        end

        // The held miss starts a fill of 0x2040; responses arrive with gaps.
        $display("[TB] fill with response gaps");
        gap_mask = 32'h0002_D9A0;
        bcnt     = 0;
        wr_start = wr_seen;
        for (int j = 1; j <= 18; j++) begin
            v = gap_mask[j];
            applyStimulus(0, 0, 16'h0, v, v ? 16'h00B0 + 16'(bcnt) : 16'h0);
            case (j)
                1: checkOutput("t4_addr_c1", mem_addr, 16'h2040);
                5: begin
                    checkOutput("t4_faddr_c5", fill_addr, 16'h2040);
                    checkOutput("t4_fdata_c5", fill_data, 16'h00B0);
                end
                6: begin
                    checkOutput("t4_wr_c6", write_data_array, 16'h0);
                    checkOutput("t4_busy_c6", fsm_busy, 16'h1);
                end
                7: checkOutput("t4_faddr_c7", fill_addr, 16'h2042);
                16: checkOutput("t4_busy_c16", fsm_busy, 16'h1);
                17: begin
                    checkOutput("t4_tag_c17", write_tag_array, 16'h1);
                    checkOutput("t4_faddr_c17", fill_addr, 16'h204E);
                    checkOutput("t4_fdata_c17", fill_data, 16'h00B7);
                end
                18: checkOutput("t4_busy_c18", fsm_busy, 16'h0);
                default: ;
            endcase
            if (v) bcnt++;
        end
        checkOutput("t4_write_count", 16'(wr_seen - wr_start), 16'd8);

        // Reset mid-fill, a stray valid afterwards, then a clean fill at 0xFFF0.
        $display("[TB] reset mid-fill");
        for (int k = 0; k <= 10; k++) begin
            v = (k >= 5 && k <= 7) || (k == 9);
            applyStimulus(k == 7, k == 0, 16'h5554, v, v ? 16'h00D0 + 16'(k) : 16'h0);
            case (k)
                6: checkOutput("t5_faddr_c6", fill_addr, 16'h5552);
                7: begin
                    checkOutput("t5_faddr_c7", fill_addr, 16'h5554);
                    checkOutput("t5_tag_c7", write_tag_array, 16'h0);
                end
                8: begin
                    checkOutput("t5_busy_c8", fsm_busy, 16'h0);
                    checkOutput("t5_wr_c8", write_data_array, 16'h0);
                end
                9: begin
                    checkOutput("t5_stray_wr_c9", write_data_array, 16'h0);
                    checkOutput("t5_busy_c9", fsm_busy, 16'h0);
                end
                default: ;
            endcase
        end
        for (int k = 0; k < 14; k++) begin
            v = (k >= 5 && k <= 12);
            applyStimulus(0, k == 0, 16'hFFF0, v, v ? 16'h00C0 + 16'(k - 5) : 16'h0);
            case (k)
                1: checkOutput("t5b_addr_c1", mem_addr, 16'hFFF0);
                5: checkOutput("t5b_faddr_c5", fill_addr, 16'hFFF0);
                12: begin
                    checkOutput("t5b_faddr_c12", fill_addr, 16'hFFFE);
                    checkOutput("t5b_tag_c12", write_tag_array, 16'h1);
                end
                13: checkOutput("t5b_busy_c13", fsm_busy, 16'h0);
                default: ;
            endcase
        end

        // Nonzero offset miss with 1-cycle memory: requests start at word 0.
        $display("[TB] offset miss, 1-cycle memory");
        for (int k = 0; k <= 10; k++) begin
            v = (k >= 2 && k <= 9);
            applyStimulus(0, k == 0, 16'h000E, v, v ? 16'h00E0 + 16'(k - 2) : 16'h0);
            case (k)
                1: checkOutput("t6_addr_c1", mem_addr, 16'h0000);
                2: begin
                    checkOutput("t6_faddr_c2", fill_addr, 16'h0000);
                    checkOutput("t6_wr_c2", write_data_array, 16'h1);
                end
                9: begin
                    checkOutput("t6_tag_c9", write_tag_array, 16'h1);
                    checkOutput("t6_faddr_c9", fill_addr, 16'h000E);
                end
                10: checkOutput("t6_busy_c10", fsm_busy, 16'h0);
                default: ;
            endcase
        end

        applyStimulus(0, 0, 16'h0, 0, 16'h0);
        applyStimulus(0, 0, 16'h0, 0, 16'h0);
        @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
